// File: rtl/boot_loader_arb_pkg.sv
// Shared constants and FSM state encoding for the serial boot loader / arbiter.
package boot_loader_arb_pkg;

    localparam int ADDR_W = 9;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;
    localparam logic [7:0] RSP_HALT = 8'h48;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ARG_HI    = 4'd1,
        ARG_LO    = 4'd2,
        ARG_LEN   = 4'd3,
        LOAD      = 4'd4,
        DUMP_RD   = 4'd5,
        DUMP_W1   = 4'd6,
        DUMP_CAP  = 4'd7,
        REPLY     = 4'd8,
        REPLY_GAP = 4'd9,
        START     = 4'd10,
        RUN       = 4'd11
    } state_t;

endpackage

// File: rtl/boot_loader_arb_res_mux.sv
// Combinational ownership mux: RAM and UART go to the CPU while running, else to the loader.
module res_mux #(
    parameter int ADDR_W = 9
) (
    input  logic              running,
    input  logic [ADDR_W-1:0] ld_raddr,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [7:0]        ld_dwrite,
    input  logic              ld_we,
    input  logic [7:0]        ld_tx_byte,
    input  logic              ld_transmit,
    input  logic [ADDR_W-1:0] cpu_raddr,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [7:0]        cpu_dwrite,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_tx_byte,
    input  logic              cpu_transmit,
    input  logic              tx_busy,
    input  logic              rx_received,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_dwrite,
    output logic              ram_we,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    output logic              cpu_tx_busy,
    output logic              cpu_received
);

    always_comb begin
        ram_raddr    = running ? cpu_raddr    : ld_raddr;
        ram_waddr    = running ? cpu_waddr    : ld_waddr;
        ram_dwrite   = running ? cpu_dwrite   : ld_dwrite;
        ram_we       = running ? cpu_we       : ld_we;
        tx_byte      = running ? cpu_tx_byte  : ld_tx_byte;
        transmit     = running ? cpu_transmit : ld_transmit;
        // The CPU sees a permanently busy UART and no received bytes while the monitor owns it.
        cpu_tx_busy  = running ? tx_busy      : 1'b1;
        cpu_received = running ? rx_received  : 1'b0;
    end

endmodule

// File: rtl/boot_loader_arb.sv
// Byte-command boot monitor (load / dump / run) that owns RAM and UART until the CPU is started.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a command byte
// ARG_HI    | waiting for address high byte (only bit 0 used)
// ARG_LO    | waiting for address low byte
// ARG_LEN   | waiting for length byte (0 = 256)
// LOAD      | each received byte is written to RAM
// DUMP_RD   | present RAM read address
// DUMP_W1   | RAM read latency cycle
// DUMP_CAP  | capture RAM read data into reply byte
// REPLY     | wait for UART idle, then send reply byte
// REPLY_GAP | one cycle before tx_busy is trusted again
// START     | hand RAM/UART to CPU and pulse cpu_start
// RUN       | CPU owns resources until cpu_halted
module boot_loader_arb
    import boot_loader_arb_pkg::*;
#(
    parameter int          ADDR_W  = boot_loader_arb_pkg::ADDR_W,
    parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_received,
    input  logic [7:0]        rx_byte,
    input  logic              tx_busy,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic [7:0]        ram_dread,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_dwrite,
    output logic              ram_we,
    input  logic [ADDR_W-1:0] cpu_raddr,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [7:0]        cpu_dwrite,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_tx_byte,
    input  logic              cpu_transmit,
    input  logic              cpu_halted,
    output logic              cpu_start,
    output logic [ADDR_W-1:0] cpu_startaddr,
    output logic              cpu_tx_busy,
    output logic              cpu_received,
    output logic              running
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [8:0]        count, count_nxt;
    logic              hi_bit, hi_nxt;
    logic [7:0]        cmd, cmd_nxt;
    logic [7:0]        reply, reply_nxt;
    logic              dump_mode, dump_nxt;
    logic [23:0]       timer, timer_nxt;
    logic [ADDR_W-1:0] ld_raddr, raddr_nxt;
    logic [ADDR_W-1:0] ld_waddr, waddr_nxt;
    logic [7:0]        ld_dwrite, dwrite_nxt;
    logic              ld_we, we_nxt;
    logic [7:0]        ld_tx_byte, txb_nxt;
    logic              ld_transmit, txs_nxt;
    logic              running_nxt;
    logic              start_nxt;
    logic [ADDR_W-1:0] saddr_nxt;
    logic [ADDR_W-1:0] rx_addr;

    assign rx_addr = ADDR_W'({hi_bit, rx_byte});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            hi_bit        <= 1'b0;
            cmd           <= '0;
            reply         <= '0;
            dump_mode     <= 1'b0;
            timer         <= '0;
            ld_raddr      <= '0;
            ld_waddr      <= '0;
            ld_dwrite     <= '0;
            ld_we         <= 1'b0;
            ld_tx_byte    <= '0;
            ld_transmit   <= 1'b0;
            running       <= 1'b0;
            cpu_start     <= 1'b0;
            cpu_startaddr <= '0;
        end else begin
            state         <= state_nxt;
            addr          <= addr_nxt;
            count         <= count_nxt;
            hi_bit        <= hi_nxt;
            cmd           <= cmd_nxt;
            reply         <= reply_nxt;
            dump_mode     <= dump_nxt;
            timer         <= timer_nxt;
            ld_raddr      <= raddr_nxt;
            ld_waddr      <= waddr_nxt;
            ld_dwrite     <= dwrite_nxt;
            ld_we         <= we_nxt;
            ld_tx_byte    <= txb_nxt;
            ld_transmit   <= txs_nxt;
            running       <= running_nxt;
            cpu_start     <= start_nxt;
            cpu_startaddr <= saddr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        count_nxt   = count;
        hi_nxt      = hi_bit;
        cmd_nxt     = cmd;
        reply_nxt   = reply;
        dump_nxt    = dump_mode;
        timer_nxt   = timer;
        raddr_nxt   = ld_raddr;
        waddr_nxt   = ld_waddr;
        dwrite_nxt  = ld_dwrite;
        we_nxt      = 1'b0;
        txb_nxt     = ld_tx_byte;
        txs_nxt     = 1'b0;
        running_nxt = running;
        start_nxt   = 1'b0;
        saddr_nxt   = cpu_startaddr;

        // Inter-byte watchdog: down-counter reloaded on every received byte.
        if ((state == ARG_HI || state == ARG_LO || state == ARG_LEN || state == LOAD)
                && !rx_received) begin
            if (timer == 24'd0) begin
                state_nxt = REPLY;
                reply_nxt = RSP_ERR;
                dump_nxt  = 1'b0;
            end else begin
                timer_nxt = timer - 24'd1;
            end
        end

        case (state)
            IDLE: begin
                if (rx_received) begin
                    if (rx_byte == CMD_LOAD || rx_byte == CMD_DUMP || rx_byte == CMD_RUN) begin
                        cmd_nxt   = rx_byte;
                        timer_nxt = TIMEOUT - 24'd1;
                        state_nxt = ARG_HI;
                    end else begin
                        reply_nxt = RSP_ERR;
                        dump_nxt  = 1'b0;
                        state_nxt = REPLY;
                    end
                end
            end
            ARG_HI: begin
                if (rx_received) begin
                    hi_nxt    = rx_byte[0];
                    timer_nxt = TIMEOUT - 24'd1;
                    state_nxt = ARG_LO;
                end
            end
            ARG_LO: begin
                if (rx_received) begin
                    addr_nxt = rx_addr;
                    if (cmd == CMD_RUN) begin
                        saddr_nxt = rx_addr;
                        state_nxt = START;
                    end else begin
                        timer_nxt = TIMEOUT - 24'd1;
                        state_nxt = ARG_LEN;
                    end
                end
            end
            ARG_LEN: begin
                if (rx_received) begin
                    count_nxt = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                    timer_nxt = TIMEOUT - 24'd1;
                    state_nxt = (cmd == CMD_LOAD) ? LOAD : DUMP_RD;
                end
            end
            LOAD: begin
                if (rx_received) begin
                    waddr_nxt  = addr;
                    dwrite_nxt = rx_byte;
                    we_nxt     = 1'b1;
                    addr_nxt   = addr + ADDR_W'(1);
                    count_nxt  = count - 9'd1;
                    timer_nxt  = TIMEOUT - 24'd1;
                    if (count == 9'd1) begin
                        reply_nxt = RSP_OK;
                        dump_nxt  = 1'b0;
                        state_nxt = REPLY;
                    end
                end
            end
            DUMP_RD: begin
                raddr_nxt = addr;
                dump_nxt  = 1'b1;
                state_nxt = DUMP_W1;
            end
            DUMP_W1: state_nxt = DUMP_CAP;
            DUMP_CAP: begin
                reply_nxt = ram_dread;
                addr_nxt  = addr + ADDR_W'(1);
                count_nxt = count - 9'd1;
                state_nxt = REPLY;
            end
            REPLY: begin
                if (!tx_busy) begin
                    txb_nxt   = reply;
                    txs_nxt   = 1'b1;
                    state_nxt = REPLY_GAP;
                end
            end
            REPLY_GAP: begin
                if (dump_mode && count != 9'd0) begin
                    state_nxt = DUMP_RD;
                end else begin
                    dump_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            START: begin
                running_nxt = 1'b1;
                start_nxt   = 1'b1;
                state_nxt   = RUN;
            end
            RUN: begin
                if (cpu_halted) begin
                    running_nxt = 1'b0;
                    reply_nxt   = RSP_HALT;
                    dump_nxt    = 1'b0;
                    state_nxt   = REPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    res_mux #(.ADDR_W(ADDR_W)) u_res_mux (
        .running      (running),
        .ld_raddr     (ld_raddr),
        .ld_waddr     (ld_waddr),
        .ld_dwrite    (ld_dwrite),
        .ld_we        (ld_we),
        .ld_tx_byte   (ld_tx_byte),
        .ld_transmit  (ld_transmit),
        .cpu_raddr    (cpu_raddr),
        .cpu_waddr    (cpu_waddr),
        .cpu_dwrite   (cpu_dwrite),
        .cpu_we       (cpu_we),
        .cpu_tx_byte  (cpu_tx_byte),
        .cpu_transmit (cpu_transmit),
        .tx_busy      (tx_busy),
        .rx_received  (rx_received),
        .ram_raddr    (ram_raddr),
        .ram_waddr    (ram_waddr),
        .ram_dwrite   (ram_dwrite),
        .ram_we       (ram_we),
        .tx_byte      (tx_byte),
        .transmit     (transmit),
        .cpu_tx_busy  (cpu_tx_busy),
        .cpu_received (cpu_received)
    );

endmodule
